// File: rtl/elevator_pkg.sv
// elevator_pkg: shared types and constants for the 4-floor car controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package elevator_pkg;

  localparam int NUM_FLOORS = 4;
  localparam int FLOOR_W    = 2;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  // One bit set for every floor strictly above the given floor.
  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] floor);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(floor)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // One bit set for every floor strictly below the given floor.
  function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] floor);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i < int'(floor)) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/elev_timer.sv
// elev_timer: loadable down-counter with zero flag, shared by travel and door phases.
// Latency: load value visible the cycle after load; zero flag is combinational from the count.
// Backpressure: enable low holds the count (used to freeze the timer).
module elev_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load has priority; otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/elevator_car_controller.sv
// elevator_car_controller: 4-floor car FSM, pending-call register, shared travel/door timer.
// Latency: call lands in pending on the accepting edge; motion begins on the following edge.
// Backpressure: none; define EMERGENCY_STOP_EN to add estop, which freezes motion and timers.
module elevator_car_controller
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  call_valid,
  input  logic [FLOOR_W-1:0]    floor_call,
  input  logic                  up_down_flag,
`ifdef EMERGENCY_STOP_EN
  input  logic                  estop,
`endif
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  motor_up,
  output logic                  motor_down,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TMR_MAX = max_int(TRAVEL_CYCLES, DOOR_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX);

  localparam logic [TMR_W-1:0]   TRAVEL_RELOAD = TMR_W'(TRAVEL_CYCLES - 1);
  localparam logic [TMR_W-1:0]   DOOR_RELOAD   = TMR_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR     = FLOOR_W'(NUM_FLOORS - 1);

  state_t                  state_q, state_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic                    dir_pref_q, dir_pref_d;
  logic                    last_dir_q, last_dir_d;
  logic                    motor_up_q, motor_up_d;
  logic                    motor_down_q, motor_down_d;
  logic                    door_open_q, door_open_d;

  logic                    tmr_load;
  logic [TMR_W-1:0]        tmr_val;
  logic                    tmr_en;
  logic                    tmr_zero;

  logic                    freeze;
  logic                    same_floor;
  logic                    req_above, req_below;
  logic                    req_fwd, req_rev;
  logic                    at_end;
  logic [FLOOR_W-1:0]      next_floor;
  logic [NUM_FLOORS-1:0]   set_mask, clr_mask;

`ifdef EMERGENCY_STOP_EN
  assign freeze = estop;
`else
  assign freeze = 1'b0;
`endif

  assign same_floor = call_valid && (floor_call == floor_q);
  assign req_above  = |(pending_q & above_mask(floor_q));
  assign req_below  = |(pending_q & below_mask(floor_q));
  // Forward/reverse relative to the direction of the last completed trip.
  assign req_fwd    = (last_dir_q == DIR_UP) ? req_above : req_below;
  assign req_rev    = (last_dir_q == DIR_UP) ? req_below : req_above;

  elev_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_val),
    .enable     (tmr_en),
    .zero       (tmr_zero)
  );

  // State register plus all datapath and registered-output flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      floor_q      <= '0;
      pending_q    <= '0;
      dir_pref_q   <= DIR_UP;
      last_dir_q   <= DIR_UP;
      motor_up_q   <= 1'b0;
      motor_down_q <= 1'b0;
      door_open_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      pending_q    <= pending_d;
      dir_pref_q   <= dir_pref_d;
      last_dir_q   <= last_dir_d;
      motor_up_q   <= motor_up_d;
      motor_down_q <= motor_down_d;
      door_open_q  <= door_open_d;
    end
  end

  // Next-state: call capture, direction choice, floor stepping and timer control.
  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    last_dir_d = last_dir_q;
    dir_pref_d = dir_pref_q;
    tmr_load   = 1'b0;
    tmr_val    = TRAVEL_RELOAD;
    tmr_en     = 1'b0;
    set_mask   = '0;
    clr_mask   = '0;
    at_end     = 1'b0;
    next_floor = floor_q;

    // A call for the floor the car is already serving opens/holds the door
    // instead of latching. While frozen in IDLE it is latched so it is not lost.
    if (call_valid) begin
      dir_pref_d = up_down_flag;
      if (!(same_floor && ((state_q == IDLE && !freeze) || state_q == DOOR_OPEN))) begin
        set_mask[floor_call] = 1'b1;
      end
    end

    if (!freeze) begin
      case (state_q)
        IDLE: begin
          if (same_floor || pending_q[floor_q]) begin
            clr_mask[floor_q] = 1'b1;
            state_d  = DOOR_OPEN;
            tmr_load = 1'b1;
            tmr_val  = DOOR_RELOAD;
          end else if (req_above && (!req_below || dir_pref_q == DIR_UP)) begin
            state_d  = MOVE_UP;
            tmr_load = 1'b1;
          end else if (req_below) begin
            state_d  = MOVE_DOWN;
            tmr_load = 1'b1;
          end
        end

        MOVE_UP, MOVE_DOWN: begin
          tmr_en = 1'b1;
          if (tmr_zero) begin
            at_end     = (state_q == MOVE_UP) ? (floor_q == TOP_FLOOR) : (floor_q == '0);
            next_floor = (state_q == MOVE_UP) ? floor_q + 2'd1 : floor_q - 2'd1;
            if (at_end) begin
              // Never drive past an end floor; settle and re-evaluate from IDLE.
              state_d = IDLE;
            end else begin
              floor_d = next_floor;
              if (pending_q[next_floor]) begin
                clr_mask[next_floor] = 1'b1;
                state_d    = DOOR_OPEN;
                last_dir_d = (state_q == MOVE_UP) ? DIR_UP : DIR_DOWN;
                tmr_load   = 1'b1;
                tmr_val    = DOOR_RELOAD;
              end else begin
                tmr_load = 1'b1;
              end
            end
          end
        end

        DOOR_OPEN: begin
          if (same_floor) begin
            tmr_load = 1'b1;
            tmr_val  = DOOR_RELOAD;
          end else begin
            tmr_en = 1'b1;
            if (tmr_zero) begin
              if (req_fwd) begin
                state_d  = (last_dir_q == DIR_UP) ? MOVE_UP : MOVE_DOWN;
                tmr_load = 1'b1;
              end else if (req_rev) begin
                state_d  = (last_dir_q == DIR_UP) ? MOVE_DOWN : MOVE_UP;
                tmr_load = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end

    // Arrival clear beats a capture of the same floor on the same edge.
    pending_d = (pending_q | set_mask) & ~clr_mask;
  end

  // Moore outputs decoded from the next state so they register alongside it.
  always_comb begin
    motor_up_d   = (state_d == MOVE_UP)   && !freeze;
    motor_down_d = (state_d == MOVE_DOWN) && !freeze;
    door_open_d  = (state_d == DOOR_OPEN);
  end

  assign current_floor = floor_q;
  assign motor_up      = motor_up_q;
  assign motor_down    = motor_down_q;
  assign door_open     = door_open_q;
  assign pending       = pending_q;

endmodule

// File: tb/tb_elevator_car_controller.sv
// Bench for elevator_car_controller with TRAVEL_CYCLES=4, DOOR_CYCLES=6.
// Each scenario queues per-cycle stimulus rows; the expected output of a row is
// pushed to the scoreboard when the row is driven and popped after the next edge.
module tb_elevator_car_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       call_valid = 1'b0;
  logic [1:0] floor_call = 2'd0;
  logic       up_down_flag = 1'b0;
  logic       estop_drv = 1'b0;
  logic [1:0] current_floor;
  logic       motor_up, motor_down, door_open;
  logic [3:0] pending;
  logic [8:0] obs;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  typedef struct {
    bit         rst;
    bit         cv;
    logic [1:0] fc;
    bit         ud;
    bit         es;
    logic [8:0] exp;
  } row_t;

  row_t       stim_q[$];
  logic [8:0] exp_q[$];

  elevator_car_controller #(
    .TRAVEL_CYCLES (4),
    .DOOR_CYCLES   (6)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .call_valid    (call_valid),
    .floor_call    (floor_call),
    .up_down_flag  (up_down_flag),
`ifdef EMERGENCY_STOP_EN
    .estop         (estop_drv),
`endif
    .current_floor (current_floor),
    .motor_up      (motor_up),
    .motor_down    (motor_down),
    .door_open     (door_open),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  assign obs = {current_floor, motor_up, motor_down, door_open, pending};

  // Pack an expected output word: floor, motor_up, motor_down, door_open, pending.
  function automatic logic [8:0] o(input int fl, input bit mu, input bit md, input bit dr,
                                   input logic [3:0] p);
    logic [1:0] f;
    f = fl[1:0];
    return {f, mu, md, dr, p};
  endfunction

  task automatic add(input int n, input bit rst, input bit cv, input int fc, input bit ud,
                     input bit es, input logic [8:0] e);
    row_t r;
    r.rst = rst; r.cv = cv; r.fc = fc[1:0]; r.ud = ud; r.es = es; r.exp = e;
    for (int i = 0; i < n; i++) stim_q.push_back(r);
  endtask

  // Drive one row and push its expected output to the scoreboard.
  task automatic drive_next();
    row_t r;
    r = stim_q.pop_front();
    reset        = r.rst;
    call_valid   = r.cv;
    floor_call   = r.fc;
    up_down_flag = r.ud;
    estop_drv    = r.es;
    exp_q.push_back(r.exp);
  endtask

  task automatic test_reset();
    logic [8:0] e;
    add(2, 1, 1, 3, 1, 0, o(0,0,0,0,4'b0000));   // call during reset is ignored
    add(2, 0, 0, 0, 0, 0, o(0,0,0,0,4'b0000));
    while (stim_q.size() > 0) begin
      drive_next();
      @(posedge clk); #1; cyc++;
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL reset cyc%0d: got %b want %b", cyc, obs, e);
      end
    end
  endtask

  task automatic test_single_call();
    logic [8:0] e;
    add(1, 1, 0, 0, 0, 0, o(0,0,0,0,4'b0000));
    add(1, 0, 1, 2, 1, 0, o(0,0,0,0,4'b0100));
    add(4, 0, 0, 0, 0, 0, o(0,1,0,0,4'b0100));
    add(4, 0, 0, 0, 0, 0, o(1,1,0,0,4'b0100));
    add(6, 0, 0, 0, 0, 0, o(2,0,0,1,4'b0000));
    add(2, 0, 0, 0, 0, 0, o(2,0,0,0,4'b0000));
    while (stim_q.size() > 0) begin
      drive_next();
      @(posedge clk); #1; cyc++;
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL single_call cyc%0d: got %b want %b", cyc, obs, e);
      end
    end
  endtask

  task automatic test_same_floor();
    logic [8:0] e;
    add(1, 1, 0, 0, 0, 0, o(0,0,0,0,4'b0000));
    add(1, 0, 1, 0, 1, 0, o(0,0,0,1,4'b0000));   // door opens next cycle, no bit
    add(2, 0, 0, 0, 0, 0, o(0,0,0,1,4'b0000));
    add(1, 0, 1, 0, 0, 0, o(0,0,0,1,4'b0000));   // re-press reloads the dwell
    add(5, 0, 0, 0, 0, 0, o(0,0,0,1,4'b0000));
    add(2, 0, 0, 0, 0, 0, o(0,0,0,0,4'b0000));
    while (stim_q.size() > 0) begin
      drive_next();
      @(posedge clk); #1; cyc++;
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL same_floor cyc%0d: got %b want %b", cyc, obs, e);
      end
    end
  endtask

  task automatic test_held_call();
    logic [8:0] e;
    add(1, 1, 0, 0, 0, 0, o(0,0,0,0,4'b0000));
    add(1, 0, 1, 2, 1, 0, o(0,0,0,0,4'b0100));
    add(4, 0, 1, 2, 1, 0, o(0,1,0,0,4'b0100));
    add(4, 0, 1, 2, 1, 0, o(1,1,0,0,4'b0100));
    add(1, 0, 1, 2, 1, 0, o(2,0,0,1,4'b0000));   // arrival clear beats held capture
    add(5, 0, 0, 0, 0, 0, o(2,0,0,1,4'b0000));
    add(1, 0, 0, 0, 0, 0, o(2,0,0,0,4'b0000));
    while (stim_q.size() > 0) begin
      drive_next();
      @(posedge clk); #1; cyc++;
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL held_call cyc%0d: got %b want %b", cyc, obs, e);
      end
    end
  endtask

  task automatic test_direction();
    logic [8:0] e;
    add(1, 1, 0, 0, 0, 0, o(0,0,0,0,4'b0000));
    add(1, 0, 1, 2, 1, 0, o(0,0,0,0,4'b0100));
    add(4, 0, 0, 0, 0, 0, o(0,1,0,0,4'b0100));
    add(4, 0, 0, 0, 0, 0, o(1,1,0,0,4'b0100));
    add(1, 0, 0, 0, 0, 0, o(2,0,0,1,4'b0000));
    add(1, 0, 1, 3, 0, 0, o(2,0,0,1,4'b1000));
    add(1, 0, 1, 0, 1, 0, o(2,0,0,1,4'b1001));
    add(3, 0, 0, 0, 0, 0, o(2,0,0,1,4'b1001));
    add(4, 0, 0, 0, 0, 0, o(2,1,0,0,4'b1001));   // continues up first
    add(6, 0, 0, 0, 0, 0, o(3,0,0,1,4'b0001));
    add(4, 0, 0, 0, 0, 0, o(3,0,1,0,4'b0001));   // then reverses
    add(4, 0, 0, 0, 0, 0, o(2,0,1,0,4'b0001));
    add(4, 0, 0, 0, 0, 0, o(1,0,1,0,4'b0001));
    add(6, 0, 0, 0, 0, 0, o(0,0,0,1,4'b0000));
    add(1, 0, 0, 0, 0, 0, o(0,0,0,0,4'b0000));
    while (stim_q.size() > 0) begin
      drive_next();
      @(posedge clk); #1; cyc++;
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL direction cyc%0d: got %b want %b", cyc, obs, e);
      end
    end
  endtask

  task automatic test_dir_pref();
    logic [8:0] e;
    add(1, 1, 0, 0, 0, 0, o(0,0,0,0,4'b0000));
    add(1, 0, 1, 1, 1, 0, o(0,0,0,0,4'b0010));
    add(4, 0, 0, 0, 0, 0, o(0,1,0,0,4'b0010));
    add(6, 0, 0, 0, 0, 0, o(1,0,0,1,4'b0000));
    add(1, 0, 0, 0, 0, 0, o(1,0,0,0,4'b0000));
    add(1, 0, 1, 0, 1, 0, o(1,0,0,0,4'b0001));
    add(1, 0, 1, 3, 0, 0, o(1,0,1,0,4'b1001));   // down first
    add(3, 0, 0, 0, 0, 0, o(1,0,1,0,4'b1001));
    add(6, 0, 0, 0, 0, 0, o(0,0,0,1,4'b1000));
    add(4, 0, 0, 0, 0, 0, o(0,1,0,0,4'b1000));
    while (stim_q.size() > 0) begin
      drive_next();
      @(posedge clk); #1; cyc++;
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL dir_pref cyc%0d: got %b want %b", cyc, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid_travel();
    logic [8:0] e;
    add(1, 1, 0, 0, 0, 0, o(0,0,0,0,4'b0000));
    add(1, 0, 1, 3, 1, 0, o(0,0,0,0,4'b1000));
    add(4, 0, 0, 0, 0, 0, o(0,1,0,0,4'b1000));
    add(1, 0, 0, 0, 0, 0, o(1,1,0,0,4'b1000));
    add(1, 1, 0, 0, 0, 0, o(0,0,0,0,4'b0000));
    add(3, 0, 0, 0, 0, 0, o(0,0,0,0,4'b0000));
    while (stim_q.size() > 0) begin
      drive_next();
      @(posedge clk); #1; cyc++;
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL reset_mid_travel cyc%0d: got %b want %b", cyc, obs, e);
      end
    end
  endtask

`ifdef EMERGENCY_STOP_EN
  task automatic test_estop();
    logic [8:0] e;
    add(1, 1, 0, 0, 0, 0, o(0,0,0,0,4'b0000));
    add(1, 0, 1, 2, 1, 0, o(0,0,0,0,4'b0100));
    add(4, 0, 0, 0, 0, 0, o(0,1,0,0,4'b0100));
    add(2, 0, 0, 0, 0, 0, o(1,1,0,0,4'b0100));
    add(2, 0, 0, 0, 0, 1, o(1,0,0,0,4'b0100));
    add(1, 0, 1, 3, 1, 1, o(1,0,0,0,4'b1100));   // capture continues while stopped
    add(2, 0, 0, 0, 0, 1, o(1,0,0,0,4'b1100));
    add(2, 0, 0, 0, 0, 0, o(1,1,0,0,4'b1100));
    add(1, 0, 0, 0, 0, 0, o(2,0,0,1,4'b1000));   // arrival five cycles late
    add(5, 0, 0, 0, 0, 0, o(2,0,0,1,4'b1000));
    add(1, 0, 0, 0, 0, 0, o(2,1,0,0,4'b1000));
    while (stim_q.size() > 0) begin
      drive_next();
      @(posedge clk); #1; cyc++;
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL estop cyc%0d: got %b want %b", cyc, obs, e);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_call();
    test_same_floor();
    test_held_call();
    test_direction();
    test_dir_pref();
    test_reset_mid_travel();
`ifdef EMERGENCY_STOP_EN
    test_estop();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
